// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
// The master drives the parallel word and load request; the slave is the serializer.
interface piso_serializer_if #(
    parameter int N = 8
);
    logic [N-1:0] i;
    logic         load;
    logic         ready;
    logic         o;
    logic         valid;
    logic         last;

    modport master (
        output i,
        output load,
        input  ready,
        input  o,
        input  valid,
        input  last
    );

    modport slave (
        input  i,
        input  load,
        output ready,
        output o,
        output valid,
        output last
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with registered outputs and optional trailing
// even-parity bit, included when the macro PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    piso_serializer_if.slave   bus
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(N - 2);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
    localparam bit PARITY_ON = 1'b1;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
    localparam bit PARITY_ON = 1'b0;
`endif

    state_t        state;
    logic [N-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic          o_q;
    logic          valid_q;
    logic          last_q;
`ifdef PISO_PARITY_EN
    logic          par_q;
`endif

    assign bus.ready = (state == IDLE);
    assign bus.o     = o_q;
    assign bus.valid = valid_q;
    assign bus.last  = last_q;

    // The flop o_q always holds the bit being presented; shreg is shifted so that
    // its next outgoing bit sits just inside the edge being consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            o_q     <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        state   <= SHIFT;
                        shreg   <= bus.i;
                        cnt     <= '0;
                        o_q     <= MSB_FIRST ? bus.i[N-1] : bus.i[0];
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
                        par_q   <= ^bus.i;
`endif
                    end else begin
                        o_q     <= 1'b0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (cnt == LAST_CNT) begin
`ifdef PISO_PARITY_EN
                        state   <= PARITY;
                        o_q     <= par_q;
                        valid_q <= 1'b1;
                        last_q  <= 1'b1;
`else
                        state   <= IDLE;
                        o_q     <= 1'b0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
`endif
                    end else begin
                        cnt     <= cnt + 1'b1;
                        shreg   <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                        o_q     <= MSB_FIRST ? shreg[N-2] : shreg[1];
                        valid_q <= 1'b1;
                        last_q  <= (cnt == PRE_LAST) && !PARITY_ON;
                    end
                end

`ifdef PISO_PARITY_EN
                PARITY: begin
                    state   <= IDLE;
                    o_q     <= 1'b0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
`endif

                default: begin
                    state   <= IDLE;
                    o_q     <= 1'b0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: three instances (N=8 LSB-first, N=8 MSB-first,
// N=2 LSB-first) share one stimulus stream; each has its own frame model and monitor.
module tb_piso_serializer;

    typedef struct packed {
        logic o;
        logic last;
    } frameBit_t;

`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        drvReset;
    logic        drvLoad;
    logic [31:0] drvData;
    logic        sawEdge = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) sawEdge <= 1'b1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ld, input logic [31:0] data);
        @(negedge clk);
        drvReset = rst;
        drvLoad  = ld;
        drvData  = data;
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int NW = (g == 2) ? 2 : 8;
        localparam bit MF = (g == 1);

        piso_serializer_if #(.N(NW)) ifc ();

        assign ifc.i    = drvData[NW-1:0];
        assign ifc.load = drvLoad;

        piso_serializer #(.N(NW), .MSB_FIRST(MF)) dut (
            .clk   (clk),
            .reset (drvReset),
            .bus   (ifc.slave)
        );

        frameBit_t sbQ[$];
        int        remaining = 0;

        // Frame model: an accepted word becomes NW (+parity) expected bits; the
        // block stays busy for exactly that many cycles after the accepting edge.
        always @(posedge clk) begin
            logic [NW-1:0] w;
            frameBit_t     e;
            if (drvReset) begin
                sbQ.delete();
                remaining = 0;
            end else if (remaining == 0) begin
                if (drvLoad) begin
                    w = drvData[NW-1:0];
                    for (int k = 0; k < NW; k++) begin
                        e.o    = MF ? w[NW-1-k] : w[k];
                        e.last = (k == NW - 1) && !PAR;
                        sbQ.push_back(e);
                    end
                    if (PAR) begin
                        e.o    = ^w;
                        e.last = 1'b1;
                        sbQ.push_back(e);
                    end
                    remaining = NW + (PAR ? 1 : 0);
                end
            end else begin
                remaining = remaining - 1;
            end
        end

        // Monitor: pops one expected bit whenever the DUT presents VALID.
        always @(negedge clk) begin
            frameBit_t e;
            if (sawEdge) begin
                checkOutput($sformatf("inst%0d ready", g), 32'(ifc.ready), 32'(remaining == 0));
                checkOutput($sformatf("inst%0d valid", g), 32'(ifc.valid), 32'(remaining != 0));
                if (ifc.valid === 1'b1) begin
                    checkOutput($sformatf("inst%0d bit-expected", g), 32'(sbQ.size() != 0), 32'd1);
                    if (sbQ.size() != 0) begin
                        e = sbQ.pop_front();
                        checkOutput($sformatf("inst%0d o", g), 32'(ifc.o), 32'(e.o));
                        checkOutput($sformatf("inst%0d last", g), 32'(ifc.last), 32'(e.last));
                    end
                end else begin
                    checkOutput($sformatf("inst%0d idle-o", g), 32'(ifc.o), 32'd0);
                    checkOutput($sformatf("inst%0d idle-last", g), 32'(ifc.last), 32'd0);
                end
            end
        end
    end

    initial begin
        drvReset = 1'b1;
        drvLoad  = 1'b0;
        drvData  = '0;
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] single frame 0xA5");
        applyStimulus(1'b0, 1'b1, 32'hA5);
        repeat (12) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] single frame 0x81");
        applyStimulus(1'b0, 1'b1, 32'h81);
        repeat (12) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] held load, data changes after accept");
        applyStimulus(1'b0, 1'b1, 32'hFF);
        repeat (25) applyStimulus(1'b0, 1'b1, 32'h00);
        repeat (12) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] reset on 4th bit, then 0x3C");
        applyStimulus(1'b0, 1'b1, 32'hE7);
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h3C);
        repeat (12) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] reset and load together");
        applyStimulus(1'b1, 1'b1, 32'h5A);
        repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] random stimulus");
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, $urandom);
        end
        repeat (14) applyStimulus(1'b0, 1'b0, 32'h0);

        checkOutput("inst0 drained", 32'(cfg[0].sbQ.size()), 32'd0);
        checkOutput("inst1 drained", 32'(cfg[1].sbQ.size()), 32'd0);
        checkOutput("inst2 drained", 32'(cfg[2].sbQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter N, default 8: parallel word width; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 0: 0 shifts LSB first, 1 shifts MSB first.
REQ-003 CLK  input  1: single clock; all state changes on the rising edge.
REQ-004 RESET  input  1: synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-005 I  input  N: parallel word to serialize; sampled only on an accepted load.
REQ-006 LOAD  input  1: load request; a load is accepted when LOAD=1 and READY=1 at a rising edge.
REQ-007 READY  output  1: high when the block can accept a load.
REQ-008 O  output  1: serial data bit, registered.
REQ-009 VALID  output  1: high on every cycle in which O carries a payload or parity bit.
REQ-010 LAST  output  1: high together with VALID on the final bit of a frame.

Function
REQ-011 States: IDLE, SHIFT, PARITY. PARITY exists only when PISO_PARITY_EN is defined.
REQ-012 IDLE: READY=1, VALID=0, LAST=0, O=0.
REQ-013 Accepted load in IDLE: capture I into the shift register, clear the bit counter, enter SHIFT.
- First payload bit appears on O with VALID=1 in the cycle after the accepting edge (latency 1).
REQ-014 SHIFT: emit one bit per cycle for exactly N cycles; no stall input exists.
- Order is I[0]..I[N-1] when MSB_FIRST=0, and I[N-1]..I[0] when MSB_FIRST=1.
REQ-015 Bit counter width is ceil(log2(N)) bits; it counts 0..N-1 and does not wrap within a frame.
REQ-016 At counter N-1 without parity: LAST=1 in that cycle, and the next state is IDLE.
REQ-017 At counter N-1 with parity: LAST=0, and the next state is PARITY.
REQ-018 PARITY: O = XOR of all N captured bits (even parity), VALID=1, LAST=1, next state IDLE.
REQ-019 READY=0 in SHIFT and PARITY; LOAD asserted while READY=0 is ignored and is not queued.
REQ-020 Back-to-back frames: READY rises in the cycle after LAST.
- A load accepted on that edge starts the next frame with exactly one idle cycle (VALID=0) between frames.
REQ-021 A change on I after the accepting edge has no effect on the frame in flight.
REQ-022 O, VALID and LAST are driven directly from flops, with no combinational path from LOAD or I.

Reset
REQ-023 RESET=1 at a rising edge forces IDLE: READY=1, VALID=0, LAST=0, O=0, counter=0, shift register=0.
REQ-024 RESET takes priority over LOAD on the same edge; the load is dropped.
REQ-025 RESET mid-frame aborts the frame; no further VALID bits of that frame appear.
REQ-026 All outputs take their reset values from the first rising edge of CLK with RESET=1 onward.

Configuration
REQ-027 Macro PISO_PARITY_EN.
- Defined: the PARITY state is included and frames are N+1 bits, with parity last.
- Undefined: the PARITY state and its logic are absent, and frames are N bits.
- The port list is identical in both builds.

Verification
REQ-028 N=8, LSB first, no parity; load I=8'hA5 from IDLE.
- Required: VALID high for 8 cycles starting 1 cycle after accept; O=1,0,1,0,0,1,0,1; LAST only on the 8th bit; READY=1 on the next cycle.
REQ-029 N=8, MSB_FIRST=1, PISO_PARITY_EN defined; load I=8'h81.
- Required: O=1,0,0,0,0,0,0,1 then parity bit 0; LAST on the 9th bit only.
REQ-030 Load 8'hFF, hold LOAD=1 continuously, change I to 8'h00 on the cycle after accept.
- Required: the first frame is all ones; the second frame (all zeros) starts after exactly one VALID=0 cycle.
REQ-031 Assert RESET on the 4th bit of a frame.
- Required: the next cycle shows VALID=0, READY=1, O=0; a load of 8'h3C accepted afterwards serializes correctly.
REQ-032 Assert RESET and LOAD on the same edge from IDLE.
- Required: no frame starts; VALID stays 0 for the following 10 cycles.
REQ-033 N=2 with parity enabled; load 2'b11.
- Required: O=1,1 then parity 0; VALID high for 3 cycles; counter boundary behaves correctly.
